// File: rtl/seq_gen_ctrl.sv
// seq_gen_ctrl: drives the weighted random-nucleotide generator to build a root
// sequence. Latches a base-frequency configuration, primes the generator, samples
// one 2-bit base per cycle, packs 16 bases per 32-bit word (base k at [2k+1:2k],
// k=0 oldest) and streams words out over a valid/ready handshake.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, cfg_len        run request (IDLE only) and length in bases (0 illegal)
//   cfg_prob_[acgt]       per-mille weights latched at start
//   abort                 cancel current run (no done/err)
//   rg_prob_[acgt]        registered weights to the generator
//   rg_result             generator output (A=00 C=01 G=10 T=11)
//   out_data/out_nbases/out_last/out_valid/out_ready   word stream
//   busy, done, err       status; done/err are one-cycle pulses
//
// Build option: define SEQ_GEN_CTRL_PROB_CHECK_EN to also reject starts whose
// weight sum is not 1000.
module seq_gen_ctrl #(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned PRIME_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [9:0]       cfg_prob_a,
  input  logic [9:0]       cfg_prob_c,
  input  logic [9:0]       cfg_prob_g,
  input  logic [9:0]       cfg_prob_t,
  input  logic             abort,
  output logic [9:0]       rg_prob_a,
  output logic [9:0]       rg_prob_c,
  output logic [9:0]       rg_prob_g,
  output logic [9:0]       rg_prob_t,
  input  logic [1:0]       rg_result,
  output logic [31:0]      out_data,
  output logic [4:0]       out_nbases,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned PW = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;

  typedef enum logic [2:0] {StIdle, StPrime, StRun, StFlush, StDone} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    prime_cnt_q, prime_cnt_d;
  logic [LEN_W-1:0] bases_left_q, bases_left_d;
  logic [31:0]      pack_q, pack_d;
  logic [4:0]       pack_cnt_q, pack_cnt_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [4:0]       out_nbases_q, out_nbases_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic [9:0]       prob_a_q, prob_a_d, prob_c_q, prob_c_d;
  logic [9:0]       prob_g_q, prob_g_d, prob_t_q, prob_t_d;
  logic             err_q, err_d;

  logic cfg_ok;
`ifdef SEQ_GEN_CTRL_PROB_CHECK_EN
  logic [11:0] prob_sum;
  assign prob_sum = {2'b00, cfg_prob_a} + {2'b00, cfg_prob_c}
                  + {2'b00, cfg_prob_g} + {2'b00, cfg_prob_t};
  assign cfg_ok   = (cfg_len != '0) && (prob_sum == 12'd1000);
`else
  assign cfg_ok   = (cfg_len != '0);
`endif

  logic       out_accept, out_free, word_pending, xfer, sample;
  logic [4:0] cnt_base;

  always_comb begin
    out_accept   = out_valid_q & out_ready;
    out_free     = ~out_valid_q | out_ready;
    // A word leaves the pack when full, or when partial after the final sample.
    word_pending = (pack_cnt_q == 5'd16) || ((state_q == StFlush) && (pack_cnt_q != '0));
    xfer         = word_pending & out_free;
    // A full pack that cannot move blocks sampling; a moving one frees slot 0.
    sample       = (state_q == StRun) && ((pack_cnt_q != 5'd16) || xfer);
    cnt_base     = xfer ? 5'd0 : pack_cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    prime_cnt_d  = prime_cnt_q;
    bases_left_d = bases_left_q;
    pack_d       = xfer ? 32'd0 : pack_q;
    pack_cnt_d   = cnt_base;
    out_data_d   = out_data_q;
    out_nbases_d = out_nbases_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q & ~out_accept;
    prob_a_d     = prob_a_q;
    prob_c_d     = prob_c_q;
    prob_g_d     = prob_g_q;
    prob_t_d     = prob_t_q;
    err_d        = 1'b0;

    if (xfer) begin
      out_data_d   = pack_q;
      out_nbases_d = pack_cnt_q;
      out_last_d   = (bases_left_q == '0);
      out_valid_d  = 1'b1;
    end

    if (sample) begin
      pack_d[{cnt_base[3:0], 1'b0} +: 2] = rg_result;
      pack_cnt_d   = cnt_base + 5'd1;
      bases_left_d = bases_left_q - 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (cfg_ok) begin
            state_d      = StPrime;
            prime_cnt_d  = '0;
            bases_left_d = cfg_len;
            pack_d       = '0;
            pack_cnt_d   = '0;
            prob_a_d     = cfg_prob_a;
            prob_c_d     = cfg_prob_c;
            prob_g_d     = cfg_prob_g;
            prob_t_d     = cfg_prob_t;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StPrime: begin
        if (prime_cnt_q == PW'(PRIME_CYC - 1)) begin
          state_d = StRun;
        end else begin
          prime_cnt_d = prime_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (sample && (bases_left_q == LEN_W'(1))) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (out_accept && out_last_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
      pack_d      = '0;
      pack_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      prime_cnt_q  <= '0;
      bases_left_q <= '0;
      pack_q       <= '0;
      pack_cnt_q   <= '0;
      out_data_q   <= '0;
      out_nbases_q <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      prob_a_q     <= '0;
      prob_c_q     <= '0;
      prob_g_q     <= '0;
      prob_t_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prime_cnt_q  <= prime_cnt_d;
      bases_left_q <= bases_left_d;
      pack_q       <= pack_d;
      pack_cnt_q   <= pack_cnt_d;
      out_data_q   <= out_data_d;
      out_nbases_q <= out_nbases_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      prob_a_q     <= prob_a_d;
      prob_c_q     <= prob_c_d;
      prob_g_q     <= prob_g_d;
      prob_t_q     <= prob_t_d;
      err_q        <= err_d;
    end
  end

  assign rg_prob_a  = prob_a_q;
  assign rg_prob_c  = prob_c_q;
  assign rg_prob_g  = prob_g_q;
  assign rg_prob_t  = prob_t_q;
  assign out_data   = out_data_q;
  assign out_nbases = out_nbases_q;
  assign out_last   = out_last_q;
  assign out_valid  = out_valid_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign err        = err_q;

endmodule

// File: tb/tb_seq_gen_ctrl.sv
// Self-checking bench for seq_gen_ctrl: directed cases plus randomized runs
// compared against a sequence-level reference model.
module tb_seq_gen_ctrl;

  localparam int unsigned LEN_W     = 16;
  localparam int unsigned PRIME_CYC = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [9:0]       cfg_prob_a = '0, cfg_prob_c = '0, cfg_prob_g = '0, cfg_prob_t = '0;
  logic             abort = 1'b0;
  logic [9:0]       rg_prob_a, rg_prob_c, rg_prob_g, rg_prob_t;
  logic [1:0]       rg_result = '0;
  logic [31:0]      out_data;
  logic [4:0]       out_nbases;
  logic             out_last, out_valid;
  logic             out_ready = 1'b0;
  logic             busy, done, err;

  seq_gen_ctrl #(.LEN_W(LEN_W), .PRIME_CYC(PRIME_CYC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cfg_len    (cfg_len),
    .cfg_prob_a (cfg_prob_a),
    .cfg_prob_c (cfg_prob_c),
    .cfg_prob_g (cfg_prob_g),
    .cfg_prob_t (cfg_prob_t),
    .abort      (abort),
    .rg_prob_a  (rg_prob_a),
    .rg_prob_c  (rg_prob_c),
    .rg_prob_g  (rg_prob_g),
    .rg_prob_t  (rg_prob_t),
    .rg_result  (rg_result),
    .out_data   (out_data),
    .out_nbases (out_nbases),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Weights of the last accepted run; a rejected start must leave these in place.
  logic [9:0] lp_a = '0, lp_c = '0, lp_g = '0, lp_t = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int len, input logic [9:0] pa, input logic [9:0] pc,
                         input logic [9:0] pg, input logic [9:0] pt);
    cfg_len    = LEN_W'(len);
    cfg_prob_a = pa;
    cfg_prob_c = pc;
    cfg_prob_g = pg;
    cfg_prob_t = pt;
  endtask

  // ready_mode: 0 always ready, 1 toggle every 3 cycles, 2 random.
  // res_mode: 0 random base each cycle (ready_mode 0 only), 1 constant res_const.
  task automatic run_seq(input int len, input logic [9:0] pa, input logic [9:0] pc,
                         input logic [9:0] pg, input logic [9:0] pt, input int ready_mode,
                         input int res_mode, input logic [1:0] res_const);
    logic [1:0]  drv [4096];
    logic [31:0] exp_data;
    logic [37:0] held;
    int          e, bidx, nb, first_valid;
    bit          acc, last_acc, stall, finished;

    set_cfg(len, pa, pc, pg, pt);
    start = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
    check("busy_after_start", busy, 1);
    check("no_err_on_start", err, 0);
    check("rg_probs", {rg_prob_a, rg_prob_c, rg_prob_g, rg_prob_t}, {pa, pc, pg, pt});
    lp_a = pa; lp_c = pc; lp_g = pg; lp_t = pt;

    bidx = 0;
    first_valid = -1;
    finished = 0;
    while (!finished && e < 3000) begin
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((e / 3) % 2) == 0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      rg_result = (res_mode == 0) ? 2'($urandom) : res_const;
      drv[e + 1] = rg_result;

      acc = out_valid && out_ready;
      last_acc = 0;
      if (acc) begin
        nb = (len - bidx > 16) ? 16 : len - bidx;
        exp_data = '0;
        for (int k = 0; k < nb; k++) begin
          // Unstalled: base i is the generator value at edge PRIME_CYC+1+i.
          exp_data[2*k +: 2] = (res_mode == 0) ? drv[PRIME_CYC + 1 + bidx + k] : res_const;
        end
        check("word_data", out_data, exp_data);
        check("word_nbases", out_nbases, nb);
        check("word_last", out_last, (bidx + nb) == len);
        bidx += nb;
        last_acc = (bidx >= len);
      end
      stall = out_valid && !out_ready;
      held  = {out_data, out_nbases, out_last};

      tick();
      e++;
      if (out_valid && first_valid < 0) first_valid = e;
      if (stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_word", {out_data, out_nbases, out_last}, held);
      end
      if (last_acc) begin
        check("done_pulse", done, 1);
        finished = 1;
      end else begin
        check("no_early_done", done, 0);
      end
    end
    if (!finished) check("run_timeout", 0, 1);
    check("total_bases", bidx, len);
    if (ready_mode == 0) begin
      check("first_valid_edge", first_valid, PRIME_CYC + 1 + ((len > 16) ? 16 : len));
    end
    out_ready = 1'b0;
    tick();
    check("done_falls", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic try_reject(input string tag, input int len, input logic [9:0] pa,
                            input logic [9:0] pc, input logic [9:0] pg,
                            input logic [9:0] pt);
    set_cfg(len, pa, pc, pg, pt);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_err"}, err, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_probs_kept"}, {rg_prob_a, rg_prob_c, rg_prob_g, rg_prob_t},
          {lp_a, lp_c, lp_g, lp_t});
    tick();
    check({tag, "_err_falls"}, err, 0);
  endtask

  initial begin
    logic [9:0] ra, rc, rg, rt;
    int         mode;

    tick();
    tick();
    check("rst_outputs", {rg_prob_a, rg_prob_c, rg_prob_g, rg_prob_t, out_data, out_nbases,
                          out_last, out_valid, busy, done, err}, '0);
    reset = 1'b0;
    tick();

    run_seq(16, 10'd250, 10'd250, 10'd250, 10'd250, 0, 0, 2'b00);
    run_seq(20, 10'd250, 10'd250, 10'd250, 10'd250, 0, 0, 2'b00);
    run_seq(40, 10'd0, 10'd0, 10'd1000, 10'd0, 1, 1, 2'b10);

    try_reject("len0", 0, 10'd250, 10'd250, 10'd250, 10'd250);
`ifdef SEQ_GEN_CTRL_PROB_CHECK_EN
    try_reject("badsum", 24, 10'd300, 10'd300, 10'd300, 10'd200);
`else
    run_seq(24, 10'd300, 10'd300, 10'd300, 10'd200, 0, 0, 2'b00);
`endif

    // Abort at edge 10 of a long run.
    set_cfg(100, 10'd250, 10'd250, 10'd250, 10'd250);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      rg_result = 2'($urandom);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort10_valid", out_valid, 0);
    check("abort10_busy", busy, 0);
    check("abort10_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort10_quiet", {done, err, busy}, '0);
    end

    // Abort while a word is parked in the output register.
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 25; i++) tick();
    check("parked_valid", out_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_parked_valid", out_valid, 0);
    check("abort_parked_busy", busy, 0);

    // Start together with abort is ignored.
    set_cfg(5, 10'd250, 10'd250, 10'd250, 10'd250);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", busy, 0);
    check("abort_start_err", err, 0);

    run_seq(17, 10'd100, 10'd200, 10'd300, 10'd400, 0, 0, 2'b00);

    // Reset mid-run.
    set_cfg(50, 10'd250, 10'd250, 10'd250, 10'd250);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 22; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_state", {busy, out_valid, rg_prob_a, rg_prob_t}, '0);
    lp_a = '0; lp_c = '0; lp_g = '0; lp_t = '0;
    tick();

    for (int i = 0; i < 8; i++) begin
      ra = 10'($urandom_range(0, 1000));
      rc = 10'($urandom_range(0, 1000 - int'(ra)));
      rg = 10'($urandom_range(0, 1000 - int'(ra) - int'(rc)));
      rt = 10'(1000 - int'(ra) - int'(rc) - int'(rg));
      mode = $urandom_range(0, 2);
      run_seq($urandom_range(1, 70), ra, rc, rg, rt, mode, (mode == 0) ? 0 : 1,
              2'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
